counter_up: RTL and testbench

COUNTER_UP -- requirements
Module: counter_up

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_up.sv | 99 +++++++++
 tb/tb_counter_up.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types for the counter_up block (FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Width of the FSM state encoding
  localparam int c_STATE_W = 2;

  // Counter FSM states
  typedef enum logic [c_STATE_W-1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } cnt_state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_up.sv
`default_nettype none
// ============================================================================
// Module      : counter_up
// Description : Up counter with terminal count LIMIT, synchronous clear and
//               clamped parallel load. Default build free-runs modulo
//               LIMIT+1 with a one-cycle wrap pulse. Defining the macro
//               COUNTER_UP_ONESHOT_EN makes the counter stop at LIMIT in
//               DONE until clr, load or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_up #(
  parameter int dw    = 8,
  parameter int LIMIT = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          clr,
  input  logic          load,
  input  logic [dw-1:0] load_val,
  output logic [dw-1:0] result,
  output logic          tc,
  output logic          wrap,
  output logic          busy
);

  import counter_pkg::*;

  localparam logic [dw-1:0] c_lim = dw'(LIMIT);
  localparam logic [dw-1:0] c_one = dw'(1);

  cnt_state_t    r_state;
  logic [dw-1:0] r_result;
  logic          r_wrap;
  logic          r_busy;

  logic [dw-1:0] w_load_clamped;
  logic          w_at_limit;

  // Terminal-count compare and load clamp; result never exceeds LIMIT
  assign w_at_limit     = (r_result == c_lim);
  assign w_load_clamped = (load_val > c_lim) ? c_lim : load_val;

  // Counter FSM: priority clr > load > ena, outputs registered with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_wrap   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // wrap is a single-cycle pulse unless re-armed below
      r_wrap <= 1'b0;
      if (clr) begin
        r_state  <= IDLE;
        r_result <= '0;
        r_busy   <= 1'b0;
      end else if (load) begin
        r_state  <= COUNT;
        r_result <= w_load_clamped;
        r_busy   <= 1'b1;
      end else if (ena) begin
        case (r_state)
          IDLE: begin
            r_state  <= COUNT;
            r_result <= r_result + c_one;
            r_busy   <= 1'b1;
          end
          COUNT: begin
            if (w_at_limit) begin
`ifdef COUNTER_UP_ONESHOT_EN
              // Stop at the terminal count; result holds at LIMIT
              r_state <= DONE;
              r_busy  <= 1'b0;
`else
              // Roll over and flag it for one cycle
              r_result <= '0;
              r_wrap   <= 1'b1;
`endif
            end else begin
              r_result <= r_result + c_one;
            end
          end
          default: begin
            // DONE ignores ena; only clr, load or reset leave it
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign result = r_result;
  assign tc     = w_at_limit;
  assign wrap   = r_wrap;
  assign busy   = r_busy;

endmodule : counter_up
`default_nettype wire

// File: tb/tb_counter_up.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_up
// Description : Scoreboard bench for counter_up (dw=8, LIMIT=7). Stimulus
//               pushes hand-computed expectations; a monitor pops and checks.
//               Expectations follow COUNTER_UP_ONESHOT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_up;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] result;
  logic       tc;
  logic       wrap;
  logic       busy;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       tc;
    logic       wrap;
    logic       busy;
  } exp_t;

  exp_t q_exp[$];
  int   total = 0;
  int   bad   = 0;
  event ev_chk;

  counter_up #(.dw(8), .LIMIT(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .result   (result),
    .tc       (tc),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are presented at every falling edge, or on demand
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_chk);
      while (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        total++;
        if ({result, tc, wrap, busy} !== {e.res, e.tc, e.wrap, e.busy}) begin
          bad++;
          $display("FAIL %s: got result=%0d tc=%b wrap=%b busy=%b, expected result=%0d tc=%b wrap=%b busy=%b",
                   e.name, result, tc, wrap, busy, e.res, e.tc, e.wrap, e.busy);
        end
      end
    end
  end

  task automatic push(input string name, input logic [7:0] r, input logic t,
                      input logic w, input logic b);
    exp_t e;
    e.name = name; e.res = r; e.tc = t; e.wrap = w; e.busy = b;
    q_exp.push_back(e);
  endtask

  // One clock of stimulus followed by its expected post-edge outputs
  task automatic step(input string name, input logic e_i, input logic c_i,
                      input logic l_i, input logic [7:0] lv,
                      input logic [7:0] r, input logic t, input logic w,
                      input logic b);
    @(negedge clk);
    ena = e_i; clr = c_i; load = l_i; load_val = lv;
    @(posedge clk);
    #1;
    push(name, r, t, w, b);
  endtask

  initial begin
    reset = 1'b0; ena = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    #3;
    push("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
    -> ev_chk;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Ten enabled cycles from reset
`ifdef COUNTER_UP_ONESHOT_EN
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("oneshot_run%0d", i), 1, 0, 0, 0,
           (i < 7) ? 8'(i) : 8'd7, (i >= 7), 1'b0, (i <= 7));
    end
    step("done_ignores_ena", 1, 0, 0, 0, 8'd7, 1, 0, 0);
`else
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("free_run%0d", i), 1, 0, 0, 0,
           8'(i % 8), (i == 7), (i == 8), 1'b1);
    end
`endif
    step("clr_to_idle", 0, 1, 0, 0, 8'd0, 0, 0, 0);
    step("idle_hold", 0, 0, 0, 0, 8'd0, 0, 0, 0);

    // Load and count on
    step("load3", 0, 0, 1, 8'd3, 8'd3, 0, 0, 1);
    step("load3_inc1", 1, 0, 0, 0, 8'd4, 0, 0, 1);
    step("load3_inc2", 1, 0, 0, 0, 8'd5, 0, 0, 1);
    step("load200_clamp", 0, 0, 1, 8'd200, 8'd7, 1, 0, 1);
    step("load_over_wrap", 1, 0, 1, 8'd2, 8'd2, 0, 0, 1);
    step("load7", 0, 0, 1, 8'd7, 8'd7, 1, 0, 1);
`ifdef COUNTER_UP_ONESHOT_EN
    step("limit_to_done", 1, 0, 0, 0, 8'd7, 1, 0, 0);
    step("load_from_done", 0, 0, 1, 8'd1, 8'd1, 0, 0, 1);
`else
    step("limit_wrap", 1, 0, 0, 0, 8'd0, 0, 1, 1);
    step("wrap_clears", 1, 0, 0, 0, 8'd1, 0, 0, 1);
`endif

    // clr beats load
    step("load4", 0, 0, 1, 8'd4, 8'd4, 0, 0, 1);
    step("clr_and_load", 0, 1, 1, 8'd5, 8'd0, 0, 0, 0);

    // Enable gating from result 2
    step("load2", 0, 0, 1, 8'd2, 8'd2, 0, 0, 1);
    step("ena_1", 1, 0, 0, 0, 8'd3, 0, 0, 1);
    step("ena_0a", 0, 0, 0, 0, 8'd3, 0, 0, 1);
    step("ena_0b", 0, 0, 0, 0, 8'd3, 0, 0, 1);
    step("ena_1b", 1, 0, 0, 0, 8'd4, 0, 0, 1);
    step("ena_to5", 1, 0, 0, 0, 8'd5, 0, 0, 1);

    // Asynchronous reset between edges at result 5
    @(negedge clk);
    ena = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    #2;
    reset = 1'b0;
    #1;
    push("async_reset", 8'd0, 0, 0, 0);
    -> ev_chk;
    @(negedge clk);
    reset = 1'b1;
    step("post_reset_hold", 0, 0, 0, 0, 8'd0, 0, 0, 0);
    step("post_reset_ena", 1, 0, 0, 0, 8'd1, 0, 0, 1);
    step("post_reset_ena2", 1, 0, 0, 0, 8'd2, 0, 0, 1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() > 0) begin
      $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
      bad   += q_exp.size();
      total += q_exp.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit
  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000, expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_counter_up
`default_nettype wire
